// File: rtl/rcc_pclk_div_ctrl.sv
// rcc_pclk_div_ctrl: applies new pclk/timer prescaler settings only on pclk boundaries, then settles and confirms.
// Optional alignment/confirm timeout with sticky err: define RCC_PCLK_DIV_CTRL_TIMEOUT_EN.
module rcc_pclk_div_ctrl #(
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic       i_clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [2:0] req_div_sel,
    input  logic       req_timpre,
    input  logic       div_en,
    output logic [2:0] div_sel,
    output logic       timpre,
    output logic       busy,
    output logic       ack,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, WAIT_ALIGN, SETTLE, CONFIRM} state_t;

    state_t           r_state;
    logic [2:0]       r_div_sel;
    logic             r_timpre;
    logic             r_busy;
    logic             r_ack;
    logic             r_err;
    logic [3:0]       r_tgt;
    logic [3:0]       r_pend;
    logic             r_pend_v;
    logic [CNT_W-1:0] r_cnt;

    logic [3:0] w_cur;
    logic [3:0] w_req;
    logic [3:0] w_sel;
    logic       w_idle_go;
    logic       w_to;

    assign w_cur     = {r_timpre, r_div_sel};
    assign w_req     = {req_timpre, req_div_sel};
    // The ack cycle is not a decision cycle: requests seen then are buffered.
    assign w_idle_go = (r_state == IDLE) && !r_ack && (r_pend_v || req);
    assign w_sel     = r_pend_v ? r_pend : w_req;

`ifdef RCC_PCLK_DIV_CTRL_TIMEOUT_EN
    assign w_to = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign w_to = 1'b0;
`endif

    assign div_sel = r_div_sel;
    assign timpre  = r_timpre;
    assign busy    = r_busy;
    assign ack     = r_ack;
    assign err     = r_err;

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_div_sel <= 3'b000;
            r_timpre  <= 1'b0;
            r_busy    <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_tgt     <= 4'b0;
            r_pend    <= 4'b0;
            r_pend_v  <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_ack <= 1'b0;
            if (req && (r_busy || r_ack || (w_idle_go && r_pend_v))) begin
                r_pend   <= w_req;
                r_pend_v <= 1'b1;
            end else if (w_idle_go && r_pend_v) begin
                r_pend_v <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_idle_go) begin
                        r_err <= 1'b0;
                        if (w_sel == w_cur) begin
                            r_ack <= 1'b1;
                        end else begin
                            r_tgt   <= w_sel;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= WAIT_ALIGN;
                        end
                    end
                end
                WAIT_ALIGN: begin
                    if (div_en || w_to) begin
                        {r_timpre, r_div_sel} <= r_tgt;
                        r_cnt   <= '0;
                        r_state <= SETTLE;
                        if (!div_en) r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (r_cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        r_cnt   <= '0;
                        r_state <= CONFIRM;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                CONFIRM: begin
                    if (div_en || w_to) begin
                        r_ack   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                        if (!div_en) r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rcc_pclk_div_ctrl.sv
// tb_rcc_pclk_div_ctrl: random requests and divider-enable patterns checked against a timestamp-based reference model.
module tb_rcc_pclk_div_ctrl;
    localparam int SETTLE = 16;
    localparam int TOC    = 64;
`ifdef RCC_PCLK_DIV_CTRL_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [2:0] req_div_sel = 3'b0;
    logic       req_timpre = 1'b0;
    logic       div_en = 1'b1;
    logic [2:0] div_sel;
    logic       timpre, busy, ack, err;

    rcc_pclk_div_ctrl dut (
        .i_clk(i_clk), .rst_n(rst_n), .req(req), .req_div_sel(req_div_sel),
        .req_timpre(req_timpre), .div_en(div_en), .div_sel(div_sel),
        .timpre(timpre), .busy(busy), .ack(ack), .err(err)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference model: applied setting, timestamps of acceptance/apply, one-deep pending queue.
    logic [3:0] m_cur, m_tgt;
    bit         m_busy, m_ack, m_err;
    int         t_req, t_apply, cyc;
    logic [3:0] pq[$];

    task automatic model_reset();
        m_cur = 4'd0; m_tgt = 4'd0;
        m_busy = 0; m_ack = 0; m_err = 0;
        t_req = -1; t_apply = -1;
        pq.delete();
    endtask

    task automatic model_step(input bit rq, input logic [3:0] v, input bit de);
        logic [3:0] s;
        logic [3:0] n_cur;
        bit n_busy, n_ack, n_err;
        n_cur = m_cur; n_busy = m_busy; n_ack = 0; n_err = m_err;
        if (!m_busy && !m_ack && (pq.size() > 0 || rq)) begin
            if (pq.size() > 0) begin
                s = pq.pop_front();
                if (rq) pq.push_back(v);
            end else begin
                s = v;
            end
            n_err = 0;
            if (s == m_cur) n_ack = 1;
            else begin
                n_busy = 1; m_tgt = s; t_req = cyc; t_apply = -1;
            end
        end else begin
            if (rq) begin
                pq.delete();
                pq.push_back(v);
            end
            if (m_busy) begin
                if (t_apply < 0) begin
                    if (de || (TO && cyc - t_req >= TOC)) begin
                        n_cur = m_tgt; t_apply = cyc;
                        if (!de) n_err = 1;
                    end
                end else if (cyc >= t_apply + SETTLE + 1 &&
                             (de || (TO && cyc - (t_apply + SETTLE + 1) >= TOC - 1))) begin
                    n_ack = 1; n_busy = 0;
                    if (!de) n_err = 1;
                end
            end
        end
        m_cur = n_cur; m_busy = n_busy; m_ack = n_ack; m_err = n_err;
    endtask

    task automatic check_outputs(input string sfx);
        check({"div_sel", sfx}, 8'(div_sel), 8'(m_cur[2:0]));
        check({"timpre", sfx}, 8'(timpre), 8'(m_cur[3]));
        check({"busy", sfx}, 8'(busy), 8'(m_busy));
        check({"ack", sfx}, 8'(ack), 8'(m_ack));
        check({"err", sfx}, 8'(err), 8'(m_err));
    endtask

    initial begin
        int per;
        bit dead, did_rst, rq, de;
        logic [3:0] v;
        cyc = 0;
        per = 1;
        did_rst = 0;
        model_reset();
        #1;
        check_outputs("_reset");
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            @(negedge i_clk);
            check_outputs("");
            if (!did_rst && c > 2000 && m_busy && t_apply >= 0 &&
                cyc > t_apply && cyc <= t_apply + SETTLE) begin
                rst_n = 1'b0;
                req = 1'b0;
                div_en = 1'b1;
                #1;
                model_reset();
                check_outputs("_midrst");
                did_rst = 1;
                @(posedge i_clk);
                #1;
                rst_n = 1'b1;
                cyc++;
                continue;
            end
            if (c % 200 == 0) begin
                case ($urandom_range(0, 4))
                    0: per = 1;
                    1: per = 2;
                    2: per = 3;
                    3: per = 4;
                    default: per = 8;
                endcase
            end
            dead = (c % 700) >= 400 && (c % 700) < 500;
            de = !dead && ((c % per) == per - 1);
            rq = ($urandom_range(0, 7) == 0);
            v = ($urandom_range(0, 3) == 0) ? m_cur : 4'($urandom_range(0, 15));
            req = rq;
            req_div_sel = v[2:0];
            req_timpre = v[3];
            div_en = de;
            model_step(rq, v, de);
            cyc++;
        end
        if (!did_rst) check("midrst_reached", 8'd0, 8'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
